// File: rtl/wb_hazard_scoreboard_if.sv
// Decode / write-back / status bundle between the pipeline latches and the
// hazard scoreboard.
interface wb_hazard_scoreboard_if #(
  parameter int NREGS = 32
);
  // decode side
  logic             issue_valid;
  logic             issue_wen;
  logic [4:0]       issue_wreg;
  logic [4:0]       dec_rs;
  logic [4:0]       dec_rt;
  logic             dec_use_rs;
  logic             dec_use_rt;
  logic             flush;
  // write-back side
  logic             wb_valid;
  logic             wb_Reg_Wen;
  logic [4:0]       wb_wreg;
  // status
  logic             stall;
  logic             issue_ack;
  logic [NREGS-1:0] busy;
  logic [31:0]      stall_cycles;
  logic             sb_err;

  modport master (
    output issue_valid, issue_wen, issue_wreg, dec_rs, dec_rt,
           dec_use_rs, dec_use_rt, flush, wb_valid, wb_Reg_Wen, wb_wreg,
    input  stall, issue_ack, busy, stall_cycles, sb_err
  );

  modport slave (
    input  issue_valid, issue_wen, issue_wreg, dec_rs, dec_rt,
           dec_use_rs, dec_use_rt, flush, wb_valid, wb_Reg_Wen, wb_wreg,
    output stall, issue_ack, busy, stall_cycles, sb_err
  );
endinterface

// File: rtl/wb_hazard_scoreboard.sv
// Per-register in-flight writer scoreboard beside decode. Counts pending
// register-file writes, stalls decode on RAW or counter-full hazards, retires
// on write-back, and keeps a stall-cycle counter plus a sticky error flag.

// One per-register in-flight counter.
module wb_hazard_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,   // issue to this register
  input  logic             dec,   // retire of this register
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] eff,   // count as seen by decode (write-first)
  output logic             bad    // underflow or overflow attempt
);
  localparam logic [CNT_W-1:0] MAX = '1;

  // A retire against an empty counter is ignored, so the bypass never wraps.
  always_comb begin
    eff = cnt;
    if (dec && cnt != '0) eff = cnt - 1'b1;
    bad = (dec & ~inc & (cnt == '0)) | (inc & ~dec & (cnt == MAX));
  end

  // Net +1/-1 per edge; simultaneous inc/dec cancels; illegal moves are held.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                            cnt <= '0;
    else if (inc && !dec && cnt != MAX)   cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)    cnt <= cnt - 1'b1;
  end
endmodule

module wb_hazard_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREGS = 32
) (
  input  logic CLK,
  input  logic nRST,
  wb_hazard_scoreboard_if.slave sb
);
  typedef logic [4:0] regbits_t;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic                        retire;
  logic [NREGS-1:0]            inc;
  logic [NREGS-1:0]            dec;
  logic [NREGS-1:0]            bad;
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0][CNT_W-1:0] eff;
  logic                        src_stall;
  logic                        str_stall;
  logic [31:0]                 stall_cnt;
  logic                        err_q;

  assign retire = sb.wb_valid & sb.wb_Reg_Wen & (sb.wb_wreg != regbits_t'(0));

  // Register 0 is never tracked.
  assign inc[0] = 1'b0;
  assign dec[0] = 1'b0;
  assign bad[0] = 1'b0;
  assign cnt[0] = '0;
  assign eff[0] = '0;

  genvar r;
  generate
    for (r = 1; r < NREGS; r++) begin : g_reg
      assign inc[r] = sb.issue_ack & sb.issue_wen & (sb.issue_wreg == regbits_t'(r));
      assign dec[r] = retire & (sb.wb_wreg == regbits_t'(r));
      wb_hazard_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (inc[r]),
        .dec  (dec[r]),
        .cnt  (cnt[r]),
        .eff  (eff[r]),
        .bad  (bad[r])
      );
      assign sb.busy[r] = (cnt[r] != '0);
    end
  endgenerate
  assign sb.busy[0] = 1'b0;

  // Hazard detection against the bypassed (post-retire) counts.
  always_comb begin
    src_stall = (sb.dec_use_rs & (sb.dec_rs != regbits_t'(0)) & (eff[sb.dec_rs] != '0)) |
                (sb.dec_use_rt & (sb.dec_rt != regbits_t'(0)) & (eff[sb.dec_rt] != '0));
    str_stall = sb.issue_wen & (sb.issue_wreg != regbits_t'(0)) & (eff[sb.issue_wreg] == MAX);
  end

  assign sb.stall     = sb.issue_valid & (src_stall | str_stall);
  assign sb.issue_ack = sb.issue_valid & ~sb.stall & ~sb.flush;

  // Saturating count of real stall cycles; flushed cycles don't count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (sb.issue_valid && sb.stall && !sb.flush && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  // Sticky consistency error; only reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     err_q <= 1'b0;
    else if (|bad) err_q <= 1'b1;
  end

  assign sb.stall_cycles = stall_cnt;
  assign sb.sb_err       = err_q;
endmodule
